// File: rtl/sevenseg_defs.sv
// sevenseg_defs: glyph table, FSM states and polarity constants shared by the 7-seg capture and encoder ends.
package sevenseg_defs;

    localparam logic       ACTIVE_LOW_ON = 1'b0;
    localparam logic [3:0] ANODE_IDLE    = 4'hF;
    localparam logic [6:0] SEG_OFF       = 7'h7F;

    typedef enum logic [1:0] {SCAN, SETTLE, HOLD} state_t;

    // Active-high {g,f,e,d,c,b,a} pattern for each hex value, indexed by nibble.
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic one_cold(input logic [3:0] an);
        return $countones(~an) == 1;
    endfunction

    function automatic logic [1:0] cold_index(input logic [3:0] an);
        return !an[0] ? 2'd0 : !an[1] ? 2'd1 : !an[2] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/sevenseg_capture_if.sv
// sevenseg_capture_if: multiplexed display drive in, captured digits and status out.
interface sevenseg_capture_if;
    logic [3:0]  anode;
    logic [6:0]  segments;
    logic        decimal_point;
    logic [15:0] digits;
    logic [3:0]  dps;
    logic [3:0]  seen;
    logic        frame_valid;
    logic [3:0]  bad_pattern;

    modport master (
        output anode, segments, decimal_point,
        input  digits, dps, seen, frame_valid, bad_pattern
    );

    modport slave (
        input  anode, segments, decimal_point,
        output digits, dps, seen, frame_valid, bad_pattern
    );
endinterface

// File: rtl/sevenseg_decode.sv
// sevenseg_decode: active-high segment pattern to hex nibble, with a flag for unknown patterns.
module sevenseg_decode
    import sevenseg_defs::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_nibble,
    output logic       o_valid
);
    always_comb begin
        o_nibble = '0;
        o_valid  = 1'b0;
        for (int i = 0; i < 16; i++)
            if (i_pattern == GLYPH[i]) begin
                o_nibble = 4'(i);
                o_valid  = 1'b1;
            end
    end
endmodule

// File: rtl/sevenseg_capture.sv
// sevenseg_capture: samples a multiplexed 4-digit 7-seg drive once each digit's select has settled,
// rebuilding the displayed hex value, decimal points and a per-frame completion pulse.
module sevenseg_capture
    import sevenseg_defs::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    sevenseg_capture_if.slave bus
);
    logic [3:0]  r_an_s1, r_an_s2;
    logic [6:0]  r_seg_s1, r_seg_s2;
    logic        r_dp_s1, r_dp_s2;
    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [3:0]  r_sel;
    logic [15:0] r_digits;
    logic [3:0]  r_dps, r_seen, r_bad;
    logic        r_fv;
    logic        w_valid, w_same, w_sample, w_glyph;
    logic [1:0]  w_idx;
    logic [3:0]  w_nib;

    assign w_valid  = one_cold(r_an_s2);
    assign w_same   = r_an_s2 == r_sel;
    assign w_idx    = cold_index(r_sel);
    assign w_sample = r_state == SETTLE && w_same && r_cnt == 8'(SETTLE_CYCLES);

    sevenseg_decode u_decode (
        .i_pattern(~r_seg_s2),
        .o_nibble (w_nib),
        .o_valid  (w_glyph)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_an_s1  <= ANODE_IDLE;
            r_an_s2  <= ANODE_IDLE;
            r_seg_s1 <= SEG_OFF;
            r_seg_s2 <= SEG_OFF;
            r_dp_s1  <= ~ACTIVE_LOW_ON;
            r_dp_s2  <= ~ACTIVE_LOW_ON;
            r_state  <= SCAN;
            r_cnt    <= '0;
            r_sel    <= ANODE_IDLE;
            r_digits <= '0;
            r_dps    <= '0;
            r_seen   <= '0;
            r_fv     <= 1'b0;
            r_bad    <= '0;
        end else begin
            r_an_s1  <= bus.anode;
            r_an_s2  <= r_an_s1;
            r_seg_s1 <= bus.segments;
            r_seg_s2 <= r_seg_s1;
            r_dp_s1  <= bus.decimal_point;
            r_dp_s2  <= r_dp_s1;
            // A full seen mask is reported one cycle later and the frame restarts.
            r_fv     <= r_seen == 4'hF;
            r_seen   <= (r_seen == 4'hF ? 4'h0 : r_seen) | (w_sample ? ~r_sel : 4'h0);
            if (w_sample) begin
                r_dps[w_idx] <= r_dp_s2 == ACTIVE_LOW_ON;
                if (w_glyph)
                    r_digits[{w_idx, 2'b00} +: 4] <= w_nib;
                else
                    r_bad[w_idx] <= 1'b1;
            end
            if (r_state == SETTLE && w_same) begin
                r_cnt   <= w_sample ? r_cnt : r_cnt + 8'd1;
                r_state <= w_sample ? HOLD : SETTLE;
            end else if (r_state == HOLD && w_same) begin
                r_state <= HOLD;
            end else if (w_valid) begin
                r_state <= SETTLE;
                r_cnt   <= 8'd1;
                r_sel   <= r_an_s2;
            end else begin
                r_state <= SCAN;
                r_cnt   <= '0;
            end
        end
    end

    assign bus.digits      = r_digits;
    assign bus.dps         = r_dps;
    assign bus.seen        = r_seen;
    assign bus.frame_valid = r_fv;
    assign bus.bad_pattern = r_bad;
endmodule

// File: tb/tb_sevenseg_capture.sv
// tb_sevenseg_capture: drives multiplexed scans and scoreboards each frame_valid against the scanned value.
module tb_sevenseg_capture;
    localparam int S = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int tests = 0;
    int fails = 0;
    int fv_count = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    sevenseg_capture_if bus();

    sevenseg_capture #(.SETTLE_CYCLES(S)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) begin
            logic [19:0] e;
            fv_count++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL frame_unexpected got digits=%h dps=%b want no frame", bus.digits, bus.dps);
            end else begin
                e = exp_q.pop_front();
                if ({bus.dps, bus.digits} !== e) begin
                    fails++;
                    $display("FAIL frame_value got dps=%b digits=%h want dps=%b digits=%h",
                             bus.dps, bus.digits, e[19:16], e[15:0]);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] an, input logic [6:0] pat, input logic dp, input int n);
        bus.anode = an;
        bus.segments = ~pat;
        bus.decimal_point = ~dp;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(4'hF, 7'h00, 1'b0, n);
    endtask

    task automatic show(input int k, input logic [6:0] pat, input logic dp, input int n);
        logic [3:0] an;
        an = ~(4'b0001 << k);
        drive(an, pat, dp, n);
    endtask

    task automatic scan(input logic [15:0] v, input logic [3:0] dpm);
        exp_q.push_back({dpm, v});
        for (int k = 3; k >= 0; k--) show(k, glyph(v[4*k +: 4]), dpm[k], 8);
    endtask

    task automatic test_reset;
        tests++;
        if (bus.digits !== 16'h0) begin fails++; $display("FAIL reset_digits got %h want 0000", bus.digits); end
        tests++;
        if (bus.dps !== 4'h0) begin fails++; $display("FAIL reset_dps got %b want 0000", bus.dps); end
        tests++;
        if (bus.seen !== 4'h0) begin fails++; $display("FAIL reset_seen got %b want 0000", bus.seen); end
        tests++;
        if (bus.frame_valid !== 1'b0) begin fails++; $display("FAIL reset_fv got %b want 0", bus.frame_valid); end
        tests++;
        if (bus.bad_pattern !== 4'h0) begin fails++; $display("FAIL reset_bad got %b want 0000", bus.bad_pattern); end
        reset_n = 1'b1;
        idle(4);
    endtask

    task automatic test_scan;
        int f0;
        f0 = fv_count;
        scan(16'h1234, 4'b0000);
        idle(10);
        tests++;
        if (fv_count - f0 !== 1) begin fails++; $display("FAIL scan_fv_count got %0d want 1", fv_count - f0); end
        tests++;
        if (bus.digits !== 16'h1234) begin fails++; $display("FAIL scan_digits got %h want 1234", bus.digits); end
        tests++;
        if (bus.dps !== 4'h0) begin fails++; $display("FAIL scan_dps got %b want 0000", bus.dps); end
        tests++;
        if (bus.bad_pattern !== 4'h0) begin fails++; $display("FAIL scan_bad got %b want 0000", bus.bad_pattern); end
        tests++;
        if (bus.seen !== 4'h0) begin fails++; $display("FAIL scan_seen_cleared got %b want 0000", bus.seen); end
    endtask

    task automatic test_short_hold;
        int f0;
        f0 = fv_count;
        show(0, glyph(4'h9), 1'b1, S - 1);
        idle(10);
        tests++;
        if (bus.seen !== 4'h0) begin fails++; $display("FAIL short_seen got %b want 0000", bus.seen); end
        tests++;
        if (bus.digits !== 16'h1234) begin fails++; $display("FAIL short_digits got %h want 1234", bus.digits); end
        tests++;
        if (fv_count !== f0) begin fails++; $display("FAIL short_fv got %0d want 0", fv_count - f0); end
    endtask

    task automatic test_bad_pattern;
        show(2, 7'h49, 1'b1, 8);
        idle(4);
        tests++;
        if (bus.bad_pattern !== 4'b0100) begin fails++; $display("FAIL bad_flag got %b want 0100", bus.bad_pattern); end
        tests++;
        if (bus.dps !== 4'b0100) begin fails++; $display("FAIL bad_dp got %b want 0100", bus.dps); end
        tests++;
        if (bus.digits !== 16'h1234) begin fails++; $display("FAIL bad_digits got %h want 1234", bus.digits); end
        tests++;
        if (bus.seen !== 4'b0100) begin fails++; $display("FAIL bad_seen got %b want 0100", bus.seen); end
        show(3, glyph(4'h1), 1'b0, 8);
        idle(4);
        tests++;
        if (bus.bad_pattern !== 4'b0100) begin fails++; $display("FAIL bad_sticky got %b want 0100", bus.bad_pattern); end
    endtask

    task automatic test_two_hot;
        int f0;
        f0 = fv_count;
        drive(4'b1100, glyph(4'h8), 1'b1, 20);
        idle(4);
        tests++;
        if ({bus.digits, bus.dps, bus.seen, bus.bad_pattern} !== {16'h1234, 4'b0100, 4'b1100, 4'b0100}) begin
            fails++;
            $display("FAIL two_hot got digits=%h dps=%b seen=%b bad=%b want 1234 0100 1100 0100",
                     bus.digits, bus.dps, bus.seen, bus.bad_pattern);
        end
        tests++;
        if (fv_count !== f0) begin fails++; $display("FAIL two_hot_fv got %0d want 0", fv_count - f0); end
    endtask

    task automatic test_reset_mid;
        int f0;
        show(3, glyph(4'hA), 1'b0, 8);
        show(2, glyph(4'hB), 1'b0, 8);
        tests++;
        if (bus.digits[15:8] !== 8'hAB) begin fails++; $display("FAIL mid_pre_digits got %h want AB", bus.digits[15:8]); end
        show(1, glyph(4'hC), 1'b0, 3);
        reset_n = 1'b0;
        #1;
        tests++;
        if ({bus.digits, bus.dps, bus.seen, bus.frame_valid, bus.bad_pattern} !== 29'h0) begin
            fails++;
            $display("FAIL mid_reset got digits=%h dps=%b seen=%b fv=%b bad=%b want all 0",
                     bus.digits, bus.dps, bus.seen, bus.frame_valid, bus.bad_pattern);
        end
        idle(3);
        reset_n = 1'b1;
        idle(2);
        f0 = fv_count;
        scan(16'hABCD, 4'b0000);
        idle(10);
        tests++;
        if (bus.digits !== 16'hABCD) begin fails++; $display("FAIL mid_digits got %h want ABCD", bus.digits); end
        tests++;
        if (fv_count - f0 !== 1) begin fails++; $display("FAIL mid_fv got %0d want 1", fv_count - f0); end
    endtask

    task automatic test_back_to_back;
        int f0;
        f0 = fv_count;
        scan(16'hF00D, 4'b0001);
        scan(16'hF00D, 4'b0001);
        idle(10);
        tests++;
        if (fv_count - f0 !== 2) begin fails++; $display("FAIL b2b_fv got %0d want 2", fv_count - f0); end
        tests++;
        if (bus.digits !== 16'hF00D) begin fails++; $display("FAIL b2b_digits got %h want F00D", bus.digits); end
        tests++;
        if (bus.dps !== 4'b0001) begin fails++; $display("FAIL b2b_dps got %b want 0001", bus.dps); end
    endtask

    initial begin
        bus.anode = 4'hF;
        bus.segments = 7'h7F;
        bus.decimal_point = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        test_scan;
        test_short_hold;
        test_bad_pattern;
        test_two_hot;
        test_reset_mid;
        test_back_to_back;
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL frames_missing got %0d pending want 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end
endmodule

// File: doc/sevenseg_capture.md
SEVENSEG_CAPTURE -- requirements
Module: sevenseg_capture

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: consecutive cycles a digit selection must hold before its segments are sampled; legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 anode  input  4  multiplexed digit select, active-low; bit 0 = rightmost digit.
REQ-005 segments  input  7  segment drive, active-low; bit order {g,f,e,d,c,b,a}.
REQ-006 decimal_point  input  1  decimal point drive, active-low.
REQ-007 digits  output  16  captured hex value; digits[4k+3:4k] = digit k.
REQ-008 dps  output  4  captured decimal points, active-high, one bit per digit.
REQ-009 seen  output  4  per-digit flag: captured at least once in the current frame.
REQ-010 frame_valid  output  1  one-cycle pulse when all four digits are captured in the current frame.
REQ-011 bad_pattern  output  4  sticky per-digit flag: a sampled pattern decoded to no hex glyph.

Function
REQ-012 anode, segments and decimal_point SHALL pass through a 2-flop synchronizer before any use; all latencies below count from the synchronized value.
REQ-013 A selection is valid only when exactly one synchronized anode bit is 0; all-ones, or multiple zeros, is invalid.
REQ-014 FSM states SCAN, SETTLE, HOLD; reset state SCAN.
REQ-015 SCAN: valid selection -> SETTLE, counter loaded with 1; otherwise remain.
REQ-016 SETTLE: selection unchanged -> counter increments; selection changed to another valid value -> restart SETTLE at 1 for the new digit; selection becomes invalid -> SCAN.
REQ-017 SETTLE: when counter equals SETTLE_CYCLES, in the same cycle sample segments/decimal_point, update that digit's nibble, dps bit and seen bit, and enter HOLD.
REQ-018 HOLD: no further sampling while the selection is unchanged; any change -> SCAN semantics, evaluated that same cycle.
REQ-019 Glyph decode (active-high pattern g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-020 Non-glyph pattern: nibble unchanged, seen bit still set, bad_pattern bit set until reset.
REQ-021 When a sample makes seen == 4'b1111, frame_valid SHALL pulse the following cycle and seen SHALL clear to 4'b0000 in that same cycle; digits/dps hold their values.
REQ-022 Re-capturing an already-seen digit within a frame overwrites its nibble and dps bit and does not advance the frame.
REQ-023 Decimal point SHALL be captured even when the segment pattern is bad.

Reset
REQ-024 reset_n low SHALL immediately force: digits=16'h0000, dps=4'b0000, seen=4'b0000, frame_valid=0, bad_pattern=4'b0000, FSM=SCAN, counter=0, synchronizer flops=all ones (inactive).
REQ-025 Reset asserted mid-SETTLE or mid-HOLD SHALL discard the partial capture; release SHALL resume from SCAN with a fresh frame.

Structure
REQ-026 Glyph constants (REQ-019), FSM state encodings and the active-low polarity constants SHALL reside in the shared package file sevenseg_defs.
REQ-027 Pattern-to-nibble decode SHALL be a combinational sub-module sevenseg_decode (in: 7-bit active-high pattern; out: nibble, valid).
REQ-028 The same package SHALL be reusable by the 7-seg encoder in system16 so both ends share one glyph table.

Verification
REQ-029 Scan 1,2,3,4 on digits 3..0, each anode held 8 cycles, dp off -> digits=16'h1234, dps=0000, one frame_valid pulse per full scan, bad_pattern=0000.
REQ-030 Digit 0 anode held for only SETTLE_CYCLES-1 synchronized cycles -> no sample, seen[0]=0, no frame_valid.
REQ-031 Digit 2 driven with pattern 7'h49 (no glyph), dp on -> bad_pattern[2]=1 and stays set, dps[2]=1, digits[11:8] unchanged.
REQ-032 anode=4'b1100 (two digits) for 20 cycles -> FSM remains in SCAN, no outputs change.
REQ-033 reset_n pulsed low during SETTLE of digit 1 after digits 3,2 were captured -> all outputs 0 at once; the next full scan of 16'hABCD yields digits=16'hABCD and one frame_valid.
REQ-034 Scan 16'hF00D with dp on digit 0 only, twice -> digits=16'hF00D, dps=0001, exactly two frame_valid pulses.
